// File: rtl/fsb_mcl_credit_bridge.sv
// fsb_mcl_credit_bridge
//   Credit-limited bridge between the host adapter and a fabric FSB node.
//   Requests (adapter -> fabric) pass through a registered tx FIFO and
//   responses (fabric -> adapter) through a registered rx FIFO. Requests
//   are only accepted while a credit is free. The credit pool is sized to
//   the rx FIFO, so every solicited response always finds a slot and the
//   fabric is never back-pressured by a slow host.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   adp_v_i/adp_data_i/adp_ready_o   request from adapter (valid/ready)
//   adp_v_o/adp_data_o/adp_ready_i   response to adapter (valid/ready)
//   fsb_v_o/fsb_data_o/fsb_yumi_i    request to fabric (valid/yumi)
//   fsb_v_i/fsb_data_i/fsb_ready_o   response from fabric (valid/ready)
//   credits_o                 free credits (combinational from state)
//   unsolicited_o             sticky: response seen with nothing outstanding
//   tx_count_o, rx_count_o    accepted request/response counters
//
// Build option
//   FSB_CREDIT_BRIDGE_STATS_EN : enables tx/rx stats counters; when it is
//   undefined both counter outputs are tied to zero.
module fsb_mcl_credit_bridge #(
    parameter int fsb_width_p = 80,
    parameter int tx_els_p    = 4,
    parameter int rx_els_p    = 16
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            adp_v_i,
    input  logic [fsb_width_p-1:0]          adp_data_i,
    output logic                            adp_ready_o,
    output logic                            adp_v_o,
    output logic [fsb_width_p-1:0]          adp_data_o,
    input  logic                            adp_ready_i,
    output logic                            fsb_v_o,
    output logic [fsb_width_p-1:0]          fsb_data_o,
    input  logic                            fsb_yumi_i,
    input  logic                            fsb_v_i,
    input  logic [fsb_width_p-1:0]          fsb_data_i,
    output logic                            fsb_ready_o,
    output logic [$clog2(rx_els_p+1)-1:0]   credits_o,
    output logic                            unsolicited_o,
    output logic [31:0]                     tx_count_o,
    output logic [31:0]                     rx_count_o
);

    localparam int tx_aw_lp  = $clog2(tx_els_p);
    localparam int rx_aw_lp  = $clog2(rx_els_p);
    localparam int cred_w_lp = $clog2(rx_els_p + 1);

    localparam logic [cred_w_lp-1:0] rx_els_c_lp = cred_w_lp'(rx_els_p);
    localparam logic [cred_w_lp:0]   rx_els_w_lp = (cred_w_lp + 1)'(rx_els_p);

    // ---------------- tx FIFO (adapter -> fabric) ----------------
    logic [fsb_width_p-1:0] tx_mem_r [tx_els_p];
    logic [tx_aw_lp:0]      tx_wptr_r, tx_rptr_r;
    logic                   tx_full, tx_empty, tx_enq, tx_deq;

    assign tx_empty = (tx_wptr_r == tx_rptr_r);
    assign tx_full  = (tx_wptr_r[tx_aw_lp] != tx_rptr_r[tx_aw_lp]) &&
                      (tx_wptr_r[tx_aw_lp-1:0] == tx_rptr_r[tx_aw_lp-1:0]);

    // ---------------- rx FIFO (fabric -> adapter) ----------------
    logic [fsb_width_p-1:0] rx_mem_r [rx_els_p];
    logic [rx_aw_lp:0]      rx_wptr_r, rx_rptr_r;
    logic                   rx_full, rx_empty, rx_enq, rx_deq;
    logic [cred_w_lp-1:0]   rx_occ;

    assign rx_empty = (rx_wptr_r == rx_rptr_r);
    assign rx_full  = (rx_wptr_r[rx_aw_lp] != rx_rptr_r[rx_aw_lp]) &&
                      (rx_wptr_r[rx_aw_lp-1:0] == rx_rptr_r[rx_aw_lp-1:0]);
    // extra pointer bit makes the difference the exact occupancy
    assign rx_occ   = cred_w_lp'(rx_wptr_r - rx_rptr_r);

    // ---------------- credit accounting ----------------
    logic [cred_w_lp-1:0] outstanding_r, outstanding_n;
    logic [cred_w_lp:0]   used;
    logic                 unsol_r;

    // one extra bit so outstanding + occupancy cannot overflow; clamp at zero
    assign used      = {1'b0, outstanding_r} + {1'b0, rx_occ};
    assign credits_o = (used >= rx_els_w_lp) ? '0 : cred_w_lp'(rx_els_w_lp - used);

    // handshake outputs are forced low while in reset
    assign adp_ready_o = !reset_i && !tx_full && (credits_o != '0);
    assign fsb_v_o     = !reset_i && !tx_empty;
    assign fsb_ready_o = !reset_i && !rx_full;
    assign adp_v_o     = !reset_i && !rx_empty;

    assign fsb_data_o  = tx_mem_r[tx_rptr_r[tx_aw_lp-1:0]];
    assign adp_data_o  = rx_mem_r[rx_rptr_r[rx_aw_lp-1:0]];

    assign tx_enq = adp_v_i && adp_ready_o;
    assign tx_deq = fsb_yumi_i && fsb_v_o;
    assign rx_enq = fsb_v_i && fsb_ready_o;
    assign rx_deq = adp_v_o && adp_ready_i;

    assign unsolicited_o = unsol_r;

    always_comb begin
        outstanding_n = outstanding_r;
        if (tx_enq && !(rx_enq && outstanding_r != '0)) begin
            if (outstanding_r != rx_els_c_lp)
                outstanding_n = outstanding_r + cred_w_lp'(1);
        end else if (!tx_enq && rx_enq && outstanding_r != '0) begin
            outstanding_n = outstanding_r - cred_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_wptr_r     <= '0;
            tx_rptr_r     <= '0;
            rx_wptr_r     <= '0;
            rx_rptr_r     <= '0;
            outstanding_r <= '0;
            unsol_r       <= 1'b0;
        end else begin
            if (tx_enq) tx_wptr_r <= tx_wptr_r + (tx_aw_lp + 1)'(1);
            if (tx_deq) tx_rptr_r <= tx_rptr_r + (tx_aw_lp + 1)'(1);
            if (rx_enq) rx_wptr_r <= rx_wptr_r + (rx_aw_lp + 1)'(1);
            if (rx_deq) rx_rptr_r <= rx_rptr_r + (rx_aw_lp + 1)'(1);
            outstanding_r <= outstanding_n;
            if (rx_enq && outstanding_r == '0) unsol_r <= 1'b1;
        end
    end

    // storage needs no reset; pointers define validity
    always_ff @(posedge clk_i) begin
        if (tx_enq) tx_mem_r[tx_wptr_r[tx_aw_lp-1:0]] <= adp_data_i;
        if (rx_enq) rx_mem_r[rx_wptr_r[rx_aw_lp-1:0]] <= fsb_data_i;
    end

`ifdef FSB_CREDIT_BRIDGE_STATS_EN
    logic [31:0] tx_count_r, rx_count_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_count_r <= '0;
            rx_count_r <= '0;
        end else begin
            if (tx_enq) tx_count_r <= tx_count_r + 32'd1;
            if (rx_enq) rx_count_r <= rx_count_r + 32'd1;
        end
    end

    assign tx_count_o = tx_count_r;
    assign rx_count_o = rx_count_r;
`else
    assign tx_count_o = '0;
    assign rx_count_o = '0;
`endif

endmodule
